// File: rtl/softmax_in_buf.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : softmax_in_buf
// Description : Input-side buffer and sequencer for the softmax engine.
//               Loads one vector from a valid/ready stream, publishes its
//               length, launches the engine, serves three combinational
//               read ports while it runs, and re-arms it after done.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module softmax_in_buf #(
  parameter int DATAWIDTH = 16,
  parameter int NUM       = 4,
  parameter int ADDRSIZE  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DATAWIDTH*NUM-1:0]  s_data,
  input  logic                      s_last,
  input  logic [ADDRSIZE-1:0]       addr,
  input  logic [ADDRSIZE-1:0]       sub0_inp_addr,
  input  logic [ADDRSIZE-1:0]       sub1_inp_addr,
  output logic [DATAWIDTH*NUM-1:0]  inp,
  output logic [DATAWIDTH*NUM-1:0]  sub0_inp,
  output logic [DATAWIDTH*NUM-1:0]  sub1_inp,
  output logic [ADDRSIZE-1:0]       addr_limit,
  output logic                      start,
  output logic                      sm_reset,
  input  logic                      sm_done,
  output logic                      busy,
  output logic                      truncated
);

  // Depth is one short of the address space so a full count fits in addr_limit.
  localparam int                  c_DEPTH    = (2 ** ADDRSIZE) - 1;
  localparam int                  c_W        = DATAWIDTH * NUM;
  localparam logic [ADDRSIZE-1:0] c_LAST_PTR = ADDRSIZE'(c_DEPTH - 1);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_REARM = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDRSIZE-1:0] r_wr_ptr;
  logic [ADDRSIZE-1:0] r_addr_limit;
  logic                r_start;
  logic                r_sm_reset;
  logic                r_truncated;
  logic                r_done_seen;
  logic [c_W-1:0]      r_mem [0:c_DEPTH-1];

  logic                w_hs;
  logic                w_at_end;
  logic                w_load_done;

  // Words are only accepted while filling; the last slot closes the load
  // even without s_last.
  assign w_hs        = s_valid && (r_state == S_FILL);
  assign w_at_end    = (r_wr_ptr == c_LAST_PTR);
  assign w_load_done = w_hs && (s_last || w_at_end);

  assign s_ready    = (r_state == S_FILL);
  assign busy       = (r_state != S_FILL);
  assign addr_limit = r_addr_limit;
  assign start      = r_start;
  assign sm_reset   = r_sm_reset;
  assign truncated  = r_truncated;

  // Zero-latency reads; anything at or beyond the loaded length reads as zero.
  assign inp      = (addr          < r_addr_limit) ? r_mem[addr]          : '0;
  assign sub0_inp = (sub0_inp_addr < r_addr_limit) ? r_mem[sub0_inp_addr] : '0;
  assign sub1_inp = (sub1_inp_addr < r_addr_limit) ? r_mem[sub1_inp_addr] : '0;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FILL;
    else       r_state <= w_state_nxt;
  end

  // Next-state: load, one launch cycle, run until the done burst ends, re-arm.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL:  if (w_load_done) w_state_nxt = S_START;
      S_START: w_state_nxt = S_RUN;
      S_RUN:   if (r_done_seen && !sm_done) w_state_nxt = S_REARM;
      S_REARM: w_state_nxt = S_FILL;
      default: w_state_nxt = S_FILL;
    endcase
  end

  // Control registers; start and sm_reset are registered copies of the
  // upcoming state so they line up exactly with START and REARM.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_addr_limit <= '0;
      r_start      <= 1'b0;
      r_sm_reset   <= 1'b1;
      r_truncated  <= 1'b0;
      r_done_seen  <= 1'b0;
    end else begin
      r_start    <= (w_state_nxt == S_START);
      r_sm_reset <= (w_state_nxt == S_REARM);

      if (w_hs)                    r_wr_ptr <= r_wr_ptr + 1'b1;
      else if (r_state == S_REARM) r_wr_ptr <= '0;

      if (w_load_done) r_addr_limit <= r_wr_ptr + 1'b1;

      if (w_hs && s_last)        r_truncated <= 1'b0;
      else if (w_hs && w_at_end) r_truncated <= 1'b1;

      if (r_state == S_RUN) begin
        if (sm_done)          r_done_seen <= 1'b1;
        else if (r_done_seen) r_done_seen <= 1'b0;
      end
    end
  end

  // Buffer write port; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (!reset && w_hs) r_mem[r_wr_ptr] <= s_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_softmax_in_buf.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_softmax_in_buf
// Description : Directed/randomized self-checking bench for softmax_in_buf
//               against a simple array-and-length reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_softmax_in_buf;

  localparam int DATAWIDTH = 16;
  localparam int NUM       = 4;
  localparam int ADDRSIZE  = 8;
  localparam int W         = DATAWIDTH * NUM;
  localparam int DEPTH     = (2 ** ADDRSIZE) - 1;

  logic                clk = 1'b0;
  logic                reset;
  logic                s_valid;
  logic                s_ready;
  logic [W-1:0]        s_data;
  logic                s_last;
  logic [ADDRSIZE-1:0] addr;
  logic [ADDRSIZE-1:0] sub0_inp_addr;
  logic [ADDRSIZE-1:0] sub1_inp_addr;
  logic [W-1:0]        inp;
  logic [W-1:0]        sub0_inp;
  logic [W-1:0]        sub1_inp;
  logic [ADDRSIZE-1:0] addr_limit;
  logic                start;
  logic                sm_reset;
  logic                sm_done;
  logic                busy;
  logic                truncated;

  int checks   = 0;
  int failures = 0;

  // Reference model: loaded words by index and the published length.
  logic [W-1:0] m_mem [0:DEPTH-1];
  int           m_lim;

  softmax_in_buf #(.DATAWIDTH(DATAWIDTH), .NUM(NUM), .ADDRSIZE(ADDRSIZE)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .addr(addr), .sub0_inp_addr(sub0_inp_addr), .sub1_inp_addr(sub1_inp_addr),
    .inp(inp), .sub0_inp(sub0_inp), .sub1_inp(sub1_inp),
    .addr_limit(addr_limit), .start(start), .sm_reset(sm_reset),
    .sm_done(sm_done), .busy(busy), .truncated(truncated)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; everything is driven and sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] model_rd(input int a);
    return (a < m_lim) ? m_mem[a] : '0;
  endfunction

  function automatic logic [W-1:0] rnd_word();
    return {$urandom, $urandom};
  endfunction

  // Present n words; on idle cycles (toggle mode) drive junk with s_last set,
  // which must not be written or end the load.
  task automatic stream(input int n, input bit with_last, input bit toggle);
    int sent = 0;
    int cyc  = 0;
    while (sent < n) begin
      if (toggle && (cyc % 2 == 1)) begin
        s_valid = 1'b0;
        s_data  = rnd_word();
        s_last  = 1'b1;
      end else begin
        s_valid = 1'b1;
        s_data  = rnd_word();
        s_last  = with_last && (sent == n - 1);
        chk($sformatf("s_ready_fill_w%0d", sent), W'(s_ready), W'(1));
        m_mem[sent] = s_data;
        sent++;
      end
      tick();
      cyc++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_lim   = n;
  endtask

  // Right after the final handshake: the launch cycle.
  task automatic check_launch(input string tag, input int n);
    chk({tag, "_start"},      W'(start),      W'(1));
    chk({tag, "_addr_limit"}, W'(addr_limit), W'(n));
    chk({tag, "_s_ready"},    W'(s_ready),    W'(0));
    chk({tag, "_busy"},       W'(busy),       W'(1));
    tick();
    chk({tag, "_start_gone"}, W'(start),      W'(0));
    chk({tag, "_busy_run"},   W'(busy),       W'(1));
  endtask

  task automatic check_reads(input string tag, input int a0, input int a1, input int a2);
    addr          = ADDRSIZE'(a0);
    sub0_inp_addr = ADDRSIZE'(a1);
    sub1_inp_addr = ADDRSIZE'(a2);
    #1;
    chk($sformatf("%s_inp@%0d",  tag, a0), inp,      model_rd(a0));
    chk($sformatf("%s_sub0@%0d", tag, a1), sub0_inp, model_rd(a1));
    chk($sformatf("%s_sub1@%0d", tag, a2), sub1_inp, model_rd(a2));
  endtask

  task automatic random_reads(input string tag, input int k);
    for (int i = 0; i < k; i++)
      check_reads(tag, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)));
  endtask

  // Done burst of len cycles, then expect REARM one cycle after the fall and FILL after.
  task automatic done_burst(input string tag, input int len);
    sm_done = 1'b1;
    for (int i = 0; i < len; i++) begin
      tick();
      chk($sformatf("%s_no_rearm%0d", tag, i), W'(sm_reset), W'(0));
    end
    sm_done = 1'b0;
    tick();
    chk({tag, "_sm_reset"},    W'(sm_reset),   W'(1));
    chk({tag, "_rearm_ready"}, W'(s_ready),    W'(0));
    tick();
    chk({tag, "_sm_reset_1cy"}, W'(sm_reset),  W'(0));
    chk({tag, "_ready_back"},   W'(s_ready),   W'(1));
    chk({tag, "_idle"},         W'(busy),      W'(0));
    chk({tag, "_limit_kept"},   W'(addr_limit), W'(m_lim));
  endtask

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    addr = '0; sub0_inp_addr = '0; sub1_inp_addr = '0; sm_done = 1'b0;
    m_lim = 0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

    // Reset state.
    tick(); tick(); tick();
    chk("rst_sm_reset",   W'(sm_reset),   W'(1));
    chk("rst_start",      W'(start),      W'(0));
    chk("rst_addr_limit", W'(addr_limit), W'(0));
    chk("rst_s_ready",    W'(s_ready),    W'(1));
    chk("rst_busy",       W'(busy),       W'(0));
    chk("rst_truncated",  W'(truncated),  W'(0));
    reset = 1'b0;
    #1;
    chk("rst_sm_reset_hold", W'(sm_reset), W'(1));
    tick();
    chk("rst_sm_reset_fall", W'(sm_reset), W'(0));

    // Three-word vector with s_last.
    stream(3, 1'b1, 1'b0);
    check_launch("v3", 3);
    check_reads("v3", 0, 2, 5);
    random_reads("v3r", 8);

    // Done burst, then reload two words to prove the write pointer rewound.
    done_burst("d3", 3);
    stream(2, 1'b1, 1'b0);
    check_launch("v2", 2);
    check_reads("v2", 0, 1, 2);
    done_burst("d1", 1);

    // Gapped valid over four words.
    stream(4, 1'b1, 1'b1);
    check_launch("v4", 4);
    for (int i = 0; i < 4; i++) check_reads("v4", i, 3 - i, i);
    check_reads("v4", 4, 4, 255);
    done_burst("d2", 2);

    // Full buffer without s_last.
    stream(DEPTH, 1'b0, 1'b0);
    s_valid = 1'b1;
    s_data  = rnd_word();
    #1;
    chk("full_truncated",  W'(truncated), W'(1));
    chk("full_256_refused", W'(s_ready),  W'(0));
    check_launch("v255", DEPTH);
    chk("full_still_refused", W'(s_ready), W'(0));
    s_valid = 1'b0;
    check_reads("v255", 0, 254, 255);
    random_reads("v255r", 8);
    done_burst("d255", 2);
    chk("trunc_sticky_fill", W'(truncated), W'(1));
    stream(1, 1'b1, 1'b0);
    chk("trunc_cleared", W'(truncated), W'(0));
    check_launch("v1", 1);

    // Reset in RUN after done has been seen.
    sm_done = 1'b1;
    tick();
    sm_done = 1'b0;
    reset   = 1'b1;
    tick();
    m_lim = 0;
    chk("mid_s_ready",    W'(s_ready),    W'(1));
    chk("mid_busy",       W'(busy),       W'(0));
    chk("mid_addr_limit", W'(addr_limit), W'(0));
    chk("mid_sm_reset",   W'(sm_reset),   W'(1));
    chk("mid_start",      W'(start),      W'(0));
    reset = 1'b0;
    tick();
    chk("mid_sm_reset_fall", W'(sm_reset), W'(0));
    chk("mid_no_start",      W'(start),    W'(0));
    tick();
    chk("mid_still_idle",    W'(start | busy), W'(0));
    check_reads("mid", 0, 1, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
